ntt_stream_engine: RTL and testbench
====================================

# ntt_stream_engine

Parametrised successor to the single-mode NTT engine: in-place radix-2 Cooley-Tukey NTT over Z_q with runtime modulus, forward/inverse mode, a pipelined butterfly, and valid/ready streaming load/store ports instead of DPI bursts. It sits between the DMA stream fabric and the coefficient scratchpad. It owns an N-word internal buffer. Twiddles come from an external synchronous ROM holding forward and inverse tables.

## Interface
- `N_LOG`, default 12: log2 transform size, N = 2^N_LOG, legal range 2..14.
- `W`, default 64: coefficient and modulus width.
- `LAT`, default 3: butterfly pipeline depth in cycles, at least 1.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a job when IDLE; ignored otherwise.
- `inverse`, input, 1: 0 selects forward, 1 selects inverse; sampled on the accepted `start`.
- `q`, input, W: modulus, odd, q < 2^(W-1); sampled on start.
- `n_inv`, input, W: N^-1 mod q, used only when inverse; sampled on start.
- `busy`, output, 1: high from the cycle after the accepted start until done.
- `done`, output, 1: one-cycle pulse at job end.
- `in_valid` / `in_ready` / `in_data[W]`: load stream, natural coefficient order.
- `out_valid` / `out_ready` / `out_data[W]`: store stream, natural order.
- `tw_addr`, output, N_LOG-1: twiddle index.
- `tw_inv`, output, 1: table select, equal to the latched `inverse`.
- `tw_data`, input, W: twiddle value, valid one cycle after `tw_addr`.

## Operation
- States: IDLE → LOAD → CALC → STORE → DONE → IDLE.
- **IDLE**
  - `in_ready` = 0, `out_valid` = 0.
  - `start` latches `inverse`, `q` and `n_inv`, then moves to LOAD.
- **LOAD**
  - `in_ready` = 1.
  - The k-th handshake (k = 0..N-1) writes `mem[bitrev(k)]`.
  - After the N-th handshake, go to CALC. No cycle limit.
- **CALC**: N_LOG stages, s = 0..N_LOG-1, with half = 2^s.
  - Each stage issues N/2 butterflies, one per cycle. Pair p maps to group g = p >> s and j = p & (half-1).
  - Addresses: u = g·2·half + j, v = u + half.
  - `tw_addr` = j << (N_LOG-1-s).
  - Butterfly with t = w·v mod q:
    - u' = (u + t) mod q
    - v' = (u − t + q) mod q
  - The 2W-bit product is reduced exactly. All operands are < q.
  - Results write back in place at u and v.
- **Stage hazard**: the next stage does not issue until every write of the current stage has retired, giving 1+LAT bubble cycles per stage.
- **STORE**
  - Emits `mem[0..N-1]` in order.
  - When inverse, each word is (x·n_inv) mod q; otherwise x unchanged.
  - Address advances only on an `out_valid && out_ready` handshake.
- **DONE**: one cycle with `done` = 1, then IDLE.
- **Back-to-back jobs**: `start` is accepted in the cycle after DONE.
- **Busy**: `start` is ignored while busy. `q`, `n_inv` and `inverse` may change mid-job without effect.
- **Reset mid-job**: return to IDLE next cycle and drop the job. Buffer contents are undefined.

## Timing
- Reset values: `busy` = 0, `done` = 0, `in_ready` = 0, `out_valid` = 0, `out_data` = 0, `tw_addr` = 0, `tw_inv` = 0.
- Buffer read latency is 1 cycle, matching the twiddle ROM.
- Issue to writeback is 1+LAT cycles.
- CALC length is exactly N_LOG·(N/2 + 1 + LAT) cycles.
- STORE sustains 1 word/cycle while `out_ready` = 1.
  - A 2-entry output skid buffer absorbs the read latency.
  - Under backpressure, `out_data` is held stable while `out_valid` = 1 and `out_ready` = 0.
  - Words are never dropped or duplicated.
- `done` asserts the cycle after the N-th output handshake.
- `busy` falls in the same cycle that `done` rises.

## Structure
- Package `ntt_pkg` holds:
  - the state enum;
  - a `bitrev(N_LOG)` function;
  - localparams N and N/2.
- Sub-module `ntt_butterfly_pipe`, parameters W and LAT:
  - computes the modular multiply and add/sub;
  - carries the u/v write addresses and a valid bit alongside the data.
- The buffer is one 2-read/2-write array. Ports are shared between the LOAD, CALC and STORE phases, which are exclusive.

## Test plan
All scenarios use N_LOG = 3, q = 17, LAT = 3. The forward table is powers of 2 (2,4,8,16 region: `{1,2,4,8}`); the inverse table is powers of 9 (`{1,9,13,15}`).
- **Reset**: hold `rst` for 2 cycles → every output at its reset value, state IDLE.
- **Forward impulse**: load `[1,0,0,0,0,0,0,0]` → output `[1,1,1,1,1,1,1,1]`. CALC lasts 3·(4+4) = 24 cycles; `done` pulses once.
- **Forward constant**: load all ones → output `[8,0,0,0,0,0,0,0]`.
- **Inverse scaling**: `inverse` = 1, `n_inv` = 15, load `[8,0,0,0,0,0,0,0]` → all ones; `tw_inv` = 1 throughout CALC.
- **Backpressure round trip**: forward then inverse on `[3,5,0,16,1,2,7,9]` with `out_ready` toggling 1,0,1,0 → the original vector returns in order; `out_data` is stable during stalls.
- **Start and reset while busy**:
  - `start` pulsed during CALC → ignored; job result unchanged.
  - `rst` mid-CALC → `busy` = 0 next cycle; a fresh impulse job afterwards passes.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the streaming NTT engine: FSM states, default sizes
// and the bit-reversal helper used to scatter loaded coefficients.
package ntt_pkg;

    localparam int unsigned N_LOG_DEF  = 12;
    localparam int unsigned N_DEF      = 1 << N_LOG_DEF;
    localparam int unsigned HALF_N_DEF = N_DEF / 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Reverse the low nbits of k (nbits <= 16); upper bits return zero.
    function automatic logic [15:0] bitrev(input logic [15:0] k, input int nbits);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < nbits) begin
                r[4'(i)] = k[4'(nbits - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_butterfly_pipe.sv
// Cooley-Tukey butterfly over Z_q, delayed through LAT register stages.
// Ports: in_valid/in_u/in_v/in_w/q plus write-back addresses in; the same
// addresses, valid bit and results (u+t, u-t mod q with t = w*v mod q) out.
module ntt_butterfly_pipe #(
    parameter int unsigned W   = 64,
    parameter int unsigned LAT = 3,
    parameter int unsigned AW  = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_u,
    input  logic [W-1:0]  in_v,
    input  logic [W-1:0]  in_w,
    input  logic [W-1:0]  q,
    input  logic [AW-1:0] in_u_addr,
    input  logic [AW-1:0] in_v_addr,
    output logic          out_valid,
    output logic [W-1:0]  out_u,
    output logic [W-1:0]  out_v,
    output logic [AW-1:0] out_u_addr,
    output logic [AW-1:0] out_v_addr
);

    logic [2*W-1:0] prod;
    logic [W-1:0]   t;
    logic [W:0]     sum;
    logic [W-1:0]   u_new;
    logic [W-1:0]   v_new;

    // Exact reduction of the full product; operands are all below q < 2^(W-1).
    always_comb begin
        prod  = (2*W)'(in_w) * (2*W)'(in_v);
        t     = W'(prod % (2*W)'(q));
        sum   = (W+1)'(in_u) + (W+1)'(t);
        u_new = (sum >= (W+1)'(q)) ? W'(sum - (W+1)'(q)) : W'(sum);
        v_new = (in_u >= t) ? (in_u - t) : (in_u + q - t);
    end

    logic          vld_sr [LAT];
    logic [W-1:0]  u_sr   [LAT];
    logic [W-1:0]  v_sr   [LAT];
    logic [AW-1:0] ua_sr  [LAT];
    logic [AW-1:0] va_sr  [LAT];

    // Valid shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                vld_sr[i] <= 1'b0;
            end
        end else begin
            vld_sr[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    // Data and address shift chain.
    always_ff @(posedge clk) begin
        u_sr[0]  <= u_new;
        v_sr[0]  <= v_new;
        ua_sr[0] <= in_u_addr;
        va_sr[0] <= in_v_addr;
        for (int i = 1; i < LAT; i++) begin
            u_sr[i]  <= u_sr[i-1];
            v_sr[i]  <= v_sr[i-1];
            ua_sr[i] <= ua_sr[i-1];
            va_sr[i] <= va_sr[i-1];
        end
    end

    assign out_valid  = vld_sr[LAT-1];
    assign out_u      = u_sr[LAT-1];
    assign out_v      = v_sr[LAT-1];
    assign out_u_addr = ua_sr[LAT-1];
    assign out_v_addr = va_sr[LAT-1];

endmodule

// File: rtl/ntt_stream_engine.sv
// In-place radix-2 NTT engine with streaming load/store.
// Ports: start/inverse/q/n_inv job control, busy/done status, in_* load
// stream (natural order), out_* store stream (natural order), tw_addr/tw_inv
// to the synchronous twiddle ROM and tw_data back from it.
module ntt_stream_engine
    import ntt_pkg::*;
#(
    parameter int unsigned N_LOG = N_LOG_DEF,
    parameter int unsigned W     = 64,
    parameter int unsigned LAT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inverse,
    input  logic [W-1:0]     q,
    input  logic [W-1:0]     n_inv,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [N_LOG-2:0] tw_addr,
    output logic             tw_inv,
    input  logic [W-1:0]     tw_data
);

    localparam int unsigned N      = 1 << N_LOG;
    localparam int unsigned HALF_N = N / 2;
    localparam int unsigned AW     = N_LOG;
    localparam int unsigned PW     = N_LOG + 1;
    localparam int unsigned TW     = N_LOG - 1;
    localparam int unsigned SW     = $clog2(N_LOG);
    localparam int unsigned CW     = $clog2(HALF_N + LAT + 1);

    state_t state, state_nxt;
    logic   busy_nxt, done_nxt, in_ready_nxt;

    logic [W-1:0]  q_lat, n_inv_lat;
    logic [AW-1:0] ld_cnt;
    logic [SW-1:0] stage;
    logic [CW-1:0] cnt;
    logic [PW-1:0] st_ptr;
    logic [AW-1:0] out_cnt;

    logic ld_fire, pop, cnt_last, stage_last;
    logic bf_vld;

    assign ld_fire    = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign cnt_last   = (cnt == CW'(HALF_N + LAT));
    assign stage_last = (stage == SW'(N_LOG - 1));

    // Next-state and registered status decode.
    always_comb begin
        state_nxt    = state;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        in_ready_nxt = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (ld_fire && ld_cnt == AW'(N - 1)) state_nxt = CALC;
            CALC:    if (cnt_last && stage_last) state_nxt = STORE;
            STORE:   if (pop && out_cnt == AW'(N - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt     = (state_nxt == LOAD) || (state_nxt == CALC) || (state_nxt == STORE);
        done_nxt     = (state_nxt == DONE);
        in_ready_nxt = (state_nxt == LOAD);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            in_ready <= in_ready_nxt;
        end
    end

    // Job parameters captured on the accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            tw_inv    <= 1'b0;
            q_lat     <= '0;
            n_inv_lat <= '0;
        end else if (state == IDLE && start) begin
            tw_inv    <= inverse;
            q_lat     <= q;
            n_inv_lat <= n_inv;
        end
    end

    logic st_issue;

    // Phase counters, cleared while idle.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            ld_cnt  <= '0;
            stage   <= '0;
            cnt     <= '0;
            st_ptr  <= '0;
            out_cnt <= '0;
        end else begin
            if (ld_fire) ld_cnt <= ld_cnt + AW'(1);
            if (state == CALC) begin
                if (cnt_last) begin
                    cnt   <= '0;
                    stage <= stage + SW'(1);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (st_issue) st_ptr  <= st_ptr + PW'(1);
            if (pop)      out_cnt <= out_cnt + AW'(1);
        end
    end

    // Butterfly addressing: pairs issue for the first N/2 counts of a stage,
    // the remaining 1+LAT counts let the stage's writes drain.
    logic          issue;
    logic [AW-1:0] pair, half, jj, uu, vv, twx;
    always_comb begin
        issue = (state == CALC) && (cnt < CW'(HALF_N));
        pair  = AW'(cnt);
        half  = AW'(1) << stage;
        jj    = pair & (half - AW'(1));
        uu    = ((pair >> stage) << (stage + 1)) | jj;
        vv    = uu | half;
        twx   = jj << (SW'(N_LOG - 1) - stage);
    end

    logic          a_vld, b_vld;
    logic [AW-1:0] a_u, a_v, b_u, b_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld   <= 1'b0;
            b_vld   <= 1'b0;
            tw_addr <= '0;
        end else begin
            a_vld <= issue;
            b_vld <= a_vld;
            if (issue) tw_addr <= TW'(twx);
        end
    end

    always_ff @(posedge clk) begin
        a_u <= uu;
        a_v <= vv;
        b_u <= a_u;
        b_v <= a_v;
    end

    // Coefficient buffer: two read ports, two write ports.
    logic [W-1:0]  mem [N];
    logic [W-1:0]  rd_u, rd_v;
    logic [AW-1:0] ra0;
    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [W-1:0]  wd0, wd1;
    logic [W-1:0]  bf_u, bf_v;
    logic [AW-1:0] bf_ua, bf_va;

    assign ra0 = (state == STORE) ? AW'(st_ptr) : a_u;

    // Load scatters in bit-reversed order; otherwise butterfly writeback owns the ports.
    always_comb begin
        we0 = 1'b0;
        wa0 = '0;
        wd0 = '0;
        we1 = 1'b0;
        wa1 = '0;
        wd1 = '0;
        if (state == LOAD) begin
            we0 = ld_fire;
            wa0 = AW'(bitrev(16'(ld_cnt), int'(N_LOG)));
            wd0 = in_data;
        end else begin
            we0 = bf_vld;
            wa0 = bf_ua;
            wd0 = bf_u;
            we1 = bf_vld;
            wa1 = bf_va;
            wd1 = bf_v;
        end
    end

    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
        rd_u <= mem[ra0];
        rd_v <= mem[a_v];
    end

    ntt_butterfly_pipe #(
        .W   (W),
        .LAT (LAT),
        .AW  (AW)
    ) u_bf (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_vld),
        .in_u       (rd_u),
        .in_v       (rd_v),
        .in_w       (tw_data),
        .q          (q_lat),
        .in_u_addr  (b_u),
        .in_v_addr  (b_v),
        .out_valid  (bf_vld),
        .out_u      (bf_u),
        .out_v      (bf_v),
        .out_u_addr (bf_ua),
        .out_v_addr (bf_va)
    );

    // Store path: credit-gated reads into a 2-entry skid (out_data is the head).
    // Reads hold off while a final CALC write is still landing.
    logic           st_rd_vld, skid_valid;
    logic [W-1:0]   skid_data;
    logic [1:0]     occ_after;
    logic [2*W-1:0] sc_prod;
    logic [W-1:0]   push_data;

    always_comb begin
        occ_after = 2'(out_valid) + 2'(skid_valid) + 2'(st_rd_vld) - 2'(pop);
        st_issue  = (state == STORE) && (st_ptr < PW'(N)) && (occ_after < 2'd2) && !bf_vld;
        sc_prod   = (2*W)'(rd_u) * (2*W)'(n_inv_lat);
        push_data = tw_inv ? W'(sc_prod % (2*W)'(q_lat)) : rd_u;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_rd_vld <= 1'b0;
        end else begin
            st_rd_vld <= st_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                out_data <= skid_data;
                if (st_rd_vld) skid_data  <= push_data;
                else           skid_valid <= 1'b0;
            end else if (st_rd_vld) begin
                out_data <= push_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (st_rd_vld) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= push_data;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= push_data;
            end
        end
    end

endmodule

// File: tb/tb_ntt_stream_engine.sv
// Directed bench for ntt_stream_engine with N_LOG=3, q=17, LAT=3.
module tb_ntt_stream_engine;
    import ntt_pkg::*;

    localparam int unsigned N_LOG = 3;
    localparam int unsigned W     = 16;
    localparam int unsigned LAT   = 3;
    localparam int unsigned N     = 8;
    localparam int unsigned CALC_CYCLES = N_LOG * (N / 2 + 1 + LAT);

    typedef logic [W-1:0] vec_t [N];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             inverse = 1'b0;
    logic [W-1:0]     q = 16'd17;
    logic [W-1:0]     n_inv = '0;
    logic             busy, done;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [N_LOG-2:0] tw_addr;
    logic             tw_inv;
    logic [W-1:0]     tw_data = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] fwd_tab [4] = '{16'd1, 16'd2, 16'd4, 16'd8};
    logic [W-1:0] inv_tab [4] = '{16'd1, 16'd9, 16'd13, 16'd15};

    always #5 clk = ~clk;

    always @(posedge clk) tw_data <= tw_inv ? inv_tab[tw_addr] : fwd_tab[tw_addr];

    ntt_stream_engine #(.N_LOG(N_LOG), .W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inverse   (inverse),
        .q         (q),
        .n_inv     (n_inv),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .tw_addr   (tw_addr),
        .tw_inv    (tw_inv),
        .tw_data   (tw_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Direct O(N^2) transform with omega = 2 mod 17.
    function automatic vec_t dft(input vec_t x);
        vec_t y;
        int acc, pw;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int n = 0; n < N; n++) begin
                pw = 1;
                for (int e = 0; e < (n * k) % N; e++) pw = (pw * 2) % 17;
                acc = (acc + int'(x[n]) * pw) % 17;
            end
            y[k] = W'(acc);
        end
        return y;
    endfunction

    // mode: 0 plain, 1 out_ready toggling, 2 start poke mid-CALC, 3 reset mid-CALC
    task automatic run_job(input logic inv, input logic [W-1:0] nv, input vec_t vin,
                           input int mode, output vec_t vout);
        int k, cyc, n_out, calc_cyc, done_cnt, tw_bad, stall_bad, busy_bad;
        int last_hs, done_at;
        logic stalled, seen_done;
        logic [W-1:0] held;
        vout = '{default: '0};
        @(negedge clk);
        start = 1'b1; inverse = inv; q = 16'd17; n_inv = nv;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        k = 0; cyc = 0;
        while (k < N && cyc < 100) begin
            in_valid = 1'b1;
            in_data  = vin[k];
            if (in_ready) k++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("load_count", 64'(k), 64'(N));
        n_out = 0; calc_cyc = 0; done_cnt = 0; tw_bad = 0; stall_bad = 0; busy_bad = 0;
        last_hs = -10; done_at = -1;
        stalled = 1'b0; seen_done = 1'b0; held = '0; cyc = 0;
        while (!seen_done && cyc < 400) begin
            if (stalled && out_data !== held) stall_bad++;
            out_ready = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
            if (dut.state == CALC) begin
                calc_cyc++;
                if (tw_inv !== inv) tw_bad++;
            end
            if (mode == 2) begin
                start = (calc_cyc == 5) && (dut.state == CALC);
                if (start) begin inverse = ~inv; q = 16'd13; n_inv = 16'd3; end
            end
            if (mode == 3 && calc_cyc == 10) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_state", 64'(dut.state), 64'(IDLE));
                check("rst_in_ready", 64'(in_ready), 64'(0));
                rst = 1'b0;
                return;
            end
            if (out_valid && out_ready) begin
                if (n_out < N) vout[n_out] = out_data;
                n_out++;
                last_hs = cyc;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (done) begin
                done_cnt++;
                done_at = cyc;
                if (busy) busy_bad++;
                seen_done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", 64'(seen_done), 64'(1));
        check("done_low_after", 64'(done), 64'(0));
        check("done_after_last_hs", 64'(done_at), 64'(last_hs + 1));
        check("out_count", 64'(n_out), 64'(N));
        check("calc_cycles", 64'(calc_cyc), 64'(CALC_CYCLES));
        check("tw_inv_stable", 64'(tw_bad), 64'(0));
        check("busy_at_done", 64'(busy_bad), 64'(0));
        if (mode == 1) check("stall_data_stable", 64'(stall_bad), 64'(0));
    endtask

    task automatic cmp_vec(input string name, input vec_t got, input vec_t exp);
        for (int i = 0; i < N; i++) check($sformatf("%s[%0d]", name, i), 64'(got[i]), 64'(exp[i]));
    endtask

    initial begin
        vec_t imp, ones, eight, rt, fexp, r, r2;
        imp   = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        ones  = '{default: 16'd1};
        eight = '{16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        rt    = '{16'd3, 16'd5, 16'd0, 16'd16, 16'd1, 16'd2, 16'd7, 16'd9};

        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_data", 64'(out_data), 64'(0));
        check("reset_tw_addr", 64'(tw_addr), 64'(0));
        check("reset_tw_inv", 64'(tw_inv), 64'(0));
        check("reset_state", 64'(dut.state), 64'(IDLE));
        rst = 1'b0;

        run_job(1'b0, '0, imp, 0, r);
        cmp_vec("fwd_impulse", r, ones);

        run_job(1'b0, '0, ones, 0, r);
        cmp_vec("fwd_const", r, eight);

        run_job(1'b1, 16'd15, eight, 0, r);
        cmp_vec("inv_scale", r, ones);

        fexp = dft(rt);
        run_job(1'b0, '0, rt, 1, r);
        cmp_vec("rt_fwd", r, fexp);
        run_job(1'b1, 16'd15, r, 1, r2);
        cmp_vec("rt_inv", r2, rt);

        run_job(1'b0, '0, rt, 2, r);
        cmp_vec("start_poke", r, fexp);

        run_job(1'b0, '0, rt, 3, r);
        run_job(1'b0, '0, imp, 0, r);
        cmp_vec("after_rst", r, ones);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
